// File: rtl/inst_sram_bridge_pkg.sv
// Shared types and constants for the fetch-side SRAM bridge.
package inst_sram_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_DATA    = 3'd2,
        ST_HOLD    = 3'd3,
        ST_DISCARD = 3'd4
    } state_e;

    localparam logic [1:0] SIZE_WORD = 2'b10;

    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb == 2'b00);
    endfunction

endpackage

// File: rtl/inst_sram_bridge_if.sv
// SRAM-like instruction bus (req/addr_ok/data_ok) between the fetch bridge and its slave.
interface inst_sram_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();

    logic              inst_req;
    logic              inst_wr;
    logic [1:0]        inst_size;
    logic [ADDR_W-1:0] inst_addr;
    logic [DATA_W-1:0] inst_wdata;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [DATA_W-1:0] inst_rdata;

    modport master (
        output inst_req,
        output inst_wr,
        output inst_size,
        output inst_addr,
        output inst_wdata,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_wr,
        input  inst_size,
        input  inst_addr,
        input  inst_wdata,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata
    );

endinterface

// File: rtl/inst_sram_bridge.sv
// Fetch-stage bridge: one SRAM-bus read per instruction, holds the word while the pipeline stalls.
// Optional IF_ADDR_ALIGN_CHK_EN: misaligned pcF skips the bus and returns RESET_INSTR.
module inst_sram_bridge
    import inst_sram_bridge_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter logic [DATA_W-1:0] RESET_INSTR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pcF,
    input  logic              inst_en,
    input  logic              longest_stall,
    input  logic              flush_except,
    output logic [DATA_W-1:0] instrF,
    output logic              stallreq_from_if,
    inst_sram_bridge_if.master bus
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] instr_buf_q, instr_buf_d;
    logic              cancel_q, cancel_d;

    logic              req_c;
    logic [ADDR_W-1:0] addr_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            instr_buf_q <= RESET_INSTR;
            cancel_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            instr_buf_q <= instr_buf_d;
            cancel_q    <= cancel_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        instr_buf_d = instr_buf_q;
        cancel_d    = cancel_q;
        req_c       = 1'b0;
        addr_c      = addr_q;

        case (state_q)
            ST_IDLE: begin
                if (inst_en && !flush_except) begin
`ifdef IF_ADDR_ALIGN_CHK_EN
                    if (!is_word_aligned(pcF[1:0])) begin
                        // No bus cycle; the datapath reports AdEL from its own check.
                        instr_buf_d = RESET_INSTR;
                        state_d     = ST_HOLD;
                    end else begin
                        req_c   = 1'b1;
                        addr_c  = pcF;
                        addr_d  = pcF;
                        state_d = bus.inst_addr_ok ? ST_DATA : ST_ADDR;
                    end
`else
                    req_c   = 1'b1;
                    addr_c  = pcF;
                    addr_d  = pcF;
                    state_d = bus.inst_addr_ok ? ST_DATA : ST_ADDR;
`endif
                end
            end

            ST_ADDR: begin
                // A request once raised stays up until accepted, even across a flush.
                req_c  = 1'b1;
                addr_c = addr_q;
                if (flush_except) begin
                    cancel_d = 1'b1;
                end
                if (bus.inst_addr_ok) begin
                    state_d = (cancel_q || flush_except) ? ST_DISCARD : ST_DATA;
                end
            end

            ST_DATA: begin
                if (bus.inst_data_ok) begin
                    if (flush_except) begin
                        state_d = ST_IDLE;
                    end else begin
                        instr_buf_d = bus.inst_rdata;
                        state_d     = ST_HOLD;
                    end
                end else if (flush_except) begin
                    state_d = ST_DISCARD;
                end
            end

            ST_DISCARD: begin
                if (bus.inst_data_ok) begin
                    cancel_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end

            ST_HOLD: begin
                if (!longest_stall || flush_except) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign stallreq_from_if = (inst_en && (state_q != ST_HOLD))
                            || (state_q == ST_DISCARD)
                            || ((state_q == ST_ADDR) && cancel_q);

    assign instrF         = instr_buf_q;
    assign bus.inst_req   = req_c;
    assign bus.inst_addr  = addr_c;
    assign bus.inst_wr    = 1'b0;
    assign bus.inst_size  = SIZE_WORD;
    assign bus.inst_wdata = '0;

endmodule
